// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the canonical NOP and the fetch-stage state encoding.
package core_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3,
        VALID = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one req/gnt/rvalid transaction per PC, result handed to decode with valid/ready,
// and a hold signal that keeps the PC register still until the instruction (or a redirect) retires it.
module instr_fetch
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic            misalign_o,
    output logic            pc_hold_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            misalign_q, misalign_d;

    // NOTE: async reset clears every register here; there is no memory array, so nothing is left unreset.
    // NOTE: non-blocking assignments keep all flops sampling the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // instr_q and misalign_q are only non-default while in VALID, so the outputs need no masking.
    always_comb begin
        // NOTE: hold-by-default assignments first so every path assigns every signal (no latches).
        state_d    = state_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        unique case (state_q)
            IDLE: begin
                // A redirect here means pc_i is about to change; sample the new target next cycle.
                if (!redirect_i) begin
                    addr_d     = pc_i;
                    instr_d    = NOP_INSTR;
                    misalign_d = (pc_i[1:0] != 2'b00);
                    state_d    = (pc_i[1:0] != 2'b00) ? VALID : REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    state_d = imem_gnt_i ? DROP : IDLE;
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_i) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = imem_rdata_i;
                        state_d = VALID;
                    end
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            VALID: begin
                if (instr_ready_i || redirect_i) begin
                    instr_d    = NOP_INSTR;
                    misalign_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o    = (state_q == REQ);
        imem_addr_o   = addr_q;
        instr_valid_o = (state_q == VALID);
        instr_o       = instr_q;
        instr_pc_o    = addr_q;
        misalign_o    = misalign_q;
        pc_hold_o     = ~((state_q == VALID) & instr_ready_i) & ~redirect_i;
    end

endmodule
